// File: rtl/sky_fetch_stage.sv
// rtl/sky_fetch_stage.sv - instruction fetch stage with credit-limited in-order fetch queue
module sky_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        instr_valid
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FQ_DEPTH);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] q_count;
  logic [CW-1:0] inflight_nxt;
  logic [PW-1:0] q_head;
  logic [PW-1:0] q_tail;
  logic [PW-1:0] t_head;
  logic [PW-1:0] t_tail;
  logic [31:0]   q_pc   [FQ_DEPTH];
  logic [31:0]   q_data [FQ_DEPTH];
  logic [31:0]   t_pc   [FQ_DEPTH];
  logic          req_fire;
  logic          resp_drop;
  logic          q_push;
  logic          q_pop;

  // Credit: every outstanding read already owns a queue slot, so a response never
  // finds the queue full. Gated by reset_n so the request line is low during reset.
  assign imem_req_valid = reset_n && (({1'b0, inflight} + {1'b0, q_count}) < DEPTH_W);
  assign imem_req_addr  = fetch_pc;

  assign req_fire     = imem_req_valid && imem_req_ready;
  assign resp_drop    = imem_resp_valid && (drop_cnt != '0);
  assign q_push       = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
  assign q_pop        = !redirect_valid && !stall && (q_count != '0);
  assign inflight_nxt = inflight + CW'(req_fire) - CW'(imem_resp_valid);

  // Payload storage for queue and in-flight PC tracker; validity is held by the counters
  always_ff @(posedge clk) begin
    if (q_push) begin
      q_pc[q_tail]   <= t_pc[t_head];
      q_data[q_tail] <= imem_resp_data;
    end
    if (req_fire) begin
      t_pc[t_tail] <= fetch_pc;
    end
  end

  // Fetch PC, in-flight/drop accounting and queue pointers; redirect flushes the queue
  // and turns every read still outstanding after this cycle into a stale one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      q_count  <= '0;
      q_head   <= '0;
      q_tail   <= '0;
      t_head   <= '0;
      t_tail   <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (req_fire) begin
        t_tail <= t_tail + PW'(1);
      end
      if (imem_resp_valid) begin
        t_head <= t_head + PW'(1);
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        drop_cnt <= inflight_nxt;
        q_count  <= '0;
        q_head   <= '0;
        q_tail   <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (resp_drop) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (q_push) begin
          q_tail <= q_tail + PW'(1);
        end
        if (q_pop) begin
          q_head <= q_head + PW'(1);
        end
        q_count <= q_count + CW'(q_push) - CW'(q_pop);
      end
    end
  end

  // Fetch->decode register: redirect kills, stall holds, otherwise pop or insert a bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_out      <= RESET_PC;
      instruction <= 32'h0;
      instr_valid <= 1'b0;
    end else if (redirect_valid) begin
      instruction <= 32'h0;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      if (q_count != '0) begin
        pc_out      <= q_pc[q_head];
        instruction <= q_data[q_head];
        instr_valid <= 1'b1;
      end else begin
        instruction <= 32'h0;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sky_fetch_stage.sv
// tb/tb_sky_fetch_stage.sv - randomized check of sky_fetch_stage against a queue-level fetch model
module tb_sky_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        instr_valid;

  logic        b_stall = 1'b0;
  logic        b_redir = 1'b0;
  logic [31:0] b_rpc = 32'h0;
  logic        b_req_valid;
  logic        b_ready = 1'b1;
  logic [31:0] b_req_addr;
  logic        b_resp_valid = 1'b0;
  logic [31:0] b_resp_data = 32'h0;
  logic [31:0] b_pc_out;
  logic [31:0] b_instruction;
  logic        b_instr_valid;

  always #5 clk = ~clk;

  sky_fetch_stage #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .pc_out(pc_out),
    .instruction(instruction), .instr_valid(instr_valid)
  );

  sky_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FQ_DEPTH(2)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .stall(b_stall),
    .redirect_valid(b_redir), .redirect_pc(b_rpc),
    .imem_req_valid(b_req_valid), .imem_req_ready(b_ready),
    .imem_req_addr(b_req_addr), .imem_resp_valid(b_resp_valid),
    .imem_resp_data(b_resp_data), .pc_out(b_pc_out),
    .instruction(b_instruction), .instr_valid(b_instr_valid)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;

  // Model: architectural fetch PC, outstanding reads (with stale flag), fetch queue of PCs
  logic [31:0] m_fetch_pc;
  logic [31:0] m_pc_out;
  logic [31:0] m_instr;
  logic        m_valid;
  logic [31:0] m_infl_pc [$];
  bit          m_infl_stale [$];
  logic [31:0] m_fq_pc [$];

  logic [31:0] mem_addr [$];
  int          mem_due [$];

  logic        c_stall = 1'b0;
  logic        c_redir = 1'b0;
  logic        c_ready = 1'b1;
  logic [31:0] c_rpc = 32'h0;

  logic        b_pend = 1'b0;
  logic [31:0] b_pend_addr = 32'h0;
  logic [31:0] b_pcs [$];
  logic [31:0] b_ins [$];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fetch_pc = 32'h0;
    m_pc_out   = 32'h0;
    m_instr    = 32'h0;
    m_valid    = 1'b0;
    m_infl_pc.delete();
    m_infl_stale.delete();
    m_fq_pc.delete();
    mem_addr.delete();
    mem_due.delete();
    b_pend      = 1'b0;
    b_pend_addr = 32'h0;
  endtask

  // One cycle: compare outputs with the model, drive this cycle's inputs, advance the model
  task automatic body();
    logic        m_reqv;
    logic        accept;
    logic        resp;
    logic [31:0] p;
    bit          st;
    int          due;
    cyc++;
    chk("pc_out", pc_out, m_pc_out);
    chk("instruction", instruction, m_instr);
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    m_reqv = (m_infl_pc.size() + m_fq_pc.size()) < DEPTH;
    chk("req_valid", 32'(imem_req_valid), 32'(m_reqv));
    if (m_reqv) chk("req_addr", imem_req_addr, m_fetch_pc);

    if (b_instr_valid && b_pcs.size() < 3) begin
      b_pcs.push_back(b_pc_out);
      b_ins.push_back(b_instruction);
    end
    b_resp_valid = b_pend;
    b_resp_data  = mdata(b_pend_addr);
    b_pend       = b_req_valid;
    b_pend_addr  = b_req_addr;

    stall          = c_stall;
    redirect_valid = c_redir;
    redirect_pc    = c_rpc;
    imem_req_ready = c_ready;
    resp = (mem_due.size() > 0) && (mem_due[0] == cyc);
    if (resp) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mdata(mem_addr[0]);
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    accept = m_reqv && c_ready;
    if (accept) begin
      due = cyc + mem_lat;
      if (mem_due.size() > 0 && due <= mem_due[$]) due = mem_due[$] + 1;
      mem_addr.push_back(m_fetch_pc);
      mem_due.push_back(due);
    end

    if (c_redir) begin
      m_instr = 32'h0;
      m_valid = 1'b0;
    end else if (!c_stall) begin
      if (m_fq_pc.size() > 0) begin
        m_pc_out = m_fq_pc.pop_front();
        m_instr  = mdata(m_pc_out);
        m_valid  = 1'b1;
      end else begin
        m_instr = 32'h0;
        m_valid = 1'b0;
      end
    end
    if (resp && m_infl_pc.size() > 0) begin
      p  = m_infl_pc.pop_front();
      st = m_infl_stale.pop_front();
      if (!st && !c_redir) m_fq_pc.push_back(p);
    end
    if (accept) begin
      m_infl_pc.push_back(m_fetch_pc);
      m_infl_stale.push_back(1'b0);
    end
    if (c_redir) begin
      m_fq_pc.delete();
      foreach (m_infl_stale[i]) m_infl_stale[i] = 1'b1;
      m_fetch_pc = c_rpc & 32'hFFFF_FFFC;
    end else if (accept) begin
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    body();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assert reset between edges, check reset values before any clock, release on a negedge
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_wrap_pc_out", b_pc_out, 32'hFFFF_FFF8);
    model_reset();
    imem_resp_valid = 1'b0;
    b_resp_valid    = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    c_stall = 1'b0;
    c_redir = 1'b0;
    c_ready = 1'b1;
    mem_lat = 1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    body();
  endtask

  initial begin : main
    logic found;
    logic [31:0] exp_b [3];
    exp_b[0] = 32'hFFFF_FFF8;
    exp_b[1] = 32'hFFFF_FFFC;
    exp_b[2] = 32'h0000_0000;

    do_reset();
    step();
    step();
    chk("t1_no_valid_yet", 32'(instr_valid), 32'h0);
    step();
    chk("t1_first_valid", 32'(instr_valid), 32'h1);
    chk("t1_first_pc", pc_out, 32'h0000_0000);
    chk("t1_first_ins", instruction, 32'hA5A5_0000);
    step();
    chk("t1_second_pc", pc_out, 32'h0000_0004);
    chk("t1_second_ins", instruction, 32'hA5A5_0004);
    run(8);

    c_stall = 1'b1;
    run(5);
    c_stall = 1'b0;
    run(10);

    mem_lat = 2;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_infl_pc.size() == 2) found = 1'b1;
      else step();
    end
    chk("t3_two_inflight", 32'(found), 32'h1);
    c_redir = 1'b1;
    c_rpc   = 32'h0000_0103;
    step();
    c_redir = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (instr_valid) found = 1'b1;
    end
    chk("t3_valid_seen", 32'(found), 32'h1);
    chk("t3_pc", pc_out, 32'h0000_0100);
    chk("t3_ins", instruction, 32'hA5A5_0100);

    mem_lat = 1;
    run(4);
    c_ready = 1'b0;
    run(3);
    c_ready = 1'b1;
    run(10);

    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) mem_lat = (mem_lat == 1) ? 2 : 1;
      c_stall = ($urandom % 4) == 0;
      c_redir = ($urandom % 12) == 0;
      c_rpc   = (($urandom % 4) == 0) ? 32'hFFFF_FFF8 : $urandom;
      c_ready = ($urandom % 10) < 7;
      step();
    end
    c_stall = 1'b0;
    c_redir = 1'b0;
    c_ready = 1'b1;
    run(6);

    do_reset();
    step();
    step();
    step();
    chk("t6_restart_valid", 32'(instr_valid), 32'h1);
    chk("t6_restart_pc", pc_out, 32'h0000_0000);
    run(10);

    chk("t5_wrap_count", 32'(b_pcs.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < b_pcs.size()) begin
        chk("t5_wrap_pc", b_pcs[i], exp_b[i]);
        chk("t5_wrap_ins", b_ins[i], mdata(exp_b[i]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
